// File: rtl/dm_mmio_pkg.sv
// Shared definitions for the data-memory-port timer peripheral:
// register selects, CTRL field layout and the byte-lane write merge.
package dm_mmio_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_AR_BIT  = 1;
  localparam int CTRL_IRQ_BIT = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

  // Lanes with web[i]=0 take the new byte; the rest keep the old byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  web);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = web[i] ? old_v[8*i +: 8] : new_v[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_mmio_prescaler.sv
// Prescale counter: emits a one-cycle tick every prescale_i+1 enabled cycles.
// clear_i restarts the count (used when PRESCALE is rewritten).
module dm_mmio_prescaler
  import dm_mmio_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_o = enable_i && (pre_cnt_q == prescale_i);

  always_comb begin
    if (!enable_i || clear_i || tick_o) pre_cnt_d = '0;
    else                                pre_cnt_d = pre_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/dm_mmio_timer.sv
// Timer/compare peripheral responding on the SRAM-style data-memory port.
// Prescaled 32-bit counter with compare match, auto-reload and level irq.
module dm_mmio_timer
  import dm_mmio_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int SEL_W  = 3,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              OE,
  input  logic [3:0]        WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              irq
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      count_q, count_d;
  logic             match_q, match_d;
  logic [31:0]      do_q, do_d;

  logic [2:0]  sel;
  logic        wr, rd, tick, hit, w1c, pre_clear;
  logic [31:0] rdata, count_tick, merged;
  logic        addr_unused;

  // Upper address bits alias onto the same eight register slots.
  assign sel         = 3'(A[SEL_W-1:0]);
  assign addr_unused = ^A;

  assign wr        = CS && (WEB != 4'hF);
  assign rd        = CS && (WEB == 4'hF);
  assign hit       = (count_q == compare_q);
  assign w1c       = wr && (sel == REG_STATUS) && !WEB[0] && DI[0];
  assign pre_clear = wr && (sel == REG_PRESCALE);

  dm_mmio_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (ctrl_q.enable),
    .clear_i   (pre_clear),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]  = ctrl_q.enable;
        rdata[CTRL_AR_BIT]  = ctrl_q.auto_reload;
        rdata[CTRL_IRQ_BIT] = ctrl_q.irq_en;
      end
      REG_PRESCALE: rdata[PRE_W-1:0] = prescale_q;
      REG_COMPARE:  rdata = compare_q;
      REG_COUNT:    rdata = count_q;
      REG_STATUS:   rdata[0] = match_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    count_tick = count_q;
    if (tick) count_tick = (hit && ctrl_q.auto_reload) ? 32'd0 : count_q + 32'd1;
  end

  // Partial writes to COUNT merge over the tick-updated value, so unwritten lanes still advance.
  assign merged = merge_bytes((sel == REG_COUNT) ? count_tick : rdata, DI, WEB);

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_tick;
    match_d    = (tick && hit) || (match_q && !w1c);
    do_d       = rd ? rdata : do_q;
    if (wr) begin
      case (sel)
        REG_CTRL: begin
          ctrl_d.enable      = merged[CTRL_EN_BIT];
          ctrl_d.auto_reload = merged[CTRL_AR_BIT];
          ctrl_d.irq_en      = merged[CTRL_IRQ_BIT];
        end
        REG_PRESCALE: prescale_d = merged[PRE_W-1:0];
        REG_COMPARE:  compare_d  = merged;
        REG_COUNT:    count_d    = merged;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
      do_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      match_q    <= match_d;
      do_q       <= do_d;
    end
  end

  assign DO  = OE ? do_q : 32'd0;
  assign irq = match_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_dm_mmio_timer.sv
// Self-checking bench for dm_mmio_timer: directed scenarios plus a
// randomized bus run checked against a register-level reference model.
module tb_dm_mmio_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CS = 1'b0;
  logic        OE = 1'b1;
  logic [3:0]  WEB = 4'hF;
  logic [13:0] A = '0;
  logic [31:0] DI = '0;
  logic [31:0] DO;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Reference model state (register-level view of the peripheral).
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_cmp, m_cnt, m_do;
  logic        m_match;
  logic [15:0] m_phase;

  dm_mmio_timer dut (
    .clk(clk), .rst(rst), .CS(CS), .OE(OE), .WEB(WEB),
    .A(A), .DI(DI), .DO(DO), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [2:0] s);
    case (s)
      3'd0: return {29'd0, m_ctrl};
      3'd1: return {16'd0, m_pre};
      3'd2: return m_cmp;
      3'd3: return m_cnt;
      3'd4: return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic cs_v, input logic [3:0] web_v,
                            input logic [13:0] a_v, input logic [31:0] di_v);
    logic [2:0]  s;
    logic        wr, rd, tick, set, mt_n;
    logic [31:0] mask, cnt_n, tmp;
    logic [15:0] ph_n;
    if (r) begin
      m_ctrl = '0; m_pre = '0; m_cmp = '0; m_cnt = '0; m_do = '0;
      m_match = 1'b0; m_phase = '0;
      return;
    end
    s  = a_v[2:0];
    wr = cs_v && (web_v != 4'hF);
    rd = cs_v && (web_v == 4'hF);
    mask = '0;
    for (int i = 0; i < 4; i++) if (!web_v[i]) mask = mask | (32'hFF << (8*i));
    tick  = m_ctrl[0] && (m_phase == m_pre);
    set   = tick && (m_cnt == m_cmp);
    cnt_n = m_cnt;
    if (tick) cnt_n = (set && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
    ph_n = (m_ctrl[0] && !tick) ? m_phase + 16'd1 : 16'd0;
    mt_n = m_match | set;
    if (rd) m_do = reg_val(s);
    if (wr) begin
      case (s)
        3'd0: begin tmp = ({29'd0, m_ctrl} & ~mask) | (di_v & mask); m_ctrl = tmp[2:0]; end
        3'd1: begin tmp = ({16'd0, m_pre} & ~mask) | (di_v & mask); m_pre = tmp[15:0]; ph_n = 16'd0; end
        3'd2: m_cmp = (m_cmp & ~mask) | (di_v & mask);
        3'd3: cnt_n = (cnt_n & ~mask) | (di_v & mask);
        3'd4: if (!web_v[0] && di_v[0] && !set) mt_n = 1'b0;
        default: ;
      endcase
    end
    m_cnt = cnt_n; m_match = mt_n; m_phase = ph_n;
  endtask

  // One bus cycle: drive, take the edge, advance the model, settle past the edge.
  task automatic cyc(input logic cs_v, input logic [3:0] web_v,
                     input logic [13:0] a_v, input logic [31:0] di_v);
    CS = cs_v; WEB = web_v; A = a_v; DI = di_v;
    @(posedge clk);
    model_edge(rst, cs_v, web_v, a_v, di_v);
    #1;
  endtask

  task automatic wr32(input logic [13:0] a_v, input logic [31:0] d);
    cyc(1'b1, 4'h0, a_v, d);
  endtask

  task automatic rd32(input logic [13:0] a_v);
    cyc(1'b1, 4'hF, a_v, 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'hF, 14'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    OE = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd32(14'(a));
      checks++;
      if (DO !== 32'd0) begin
        failures++;
        $display("FAIL reset_read addr=%0d DO=%h expected=%h", a, DO, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq irq=%b expected=0", irq);
    end
  endtask

  task automatic test_byte_lanes();
    cyc(1'b1, 4'b1101, 14'd3, 32'h11223344);
    rd32(14'd3);
    checks++;
    if (DO !== 32'h00003300) begin
      failures++;
      $display("FAIL lane1_write DO=%h expected=%h", DO, 32'h00003300);
    end
    wr32(14'd3, 32'hAABBCCDD);
    rd32(14'd3);
    checks++;
    if (DO !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL full_write DO=%h expected=%h", DO, 32'hAABBCCDD);
    end
    OE = 1'b0; #1;
    checks++;
    if (DO !== 32'd0) begin
      failures++;
      $display("FAIL oe_low DO=%h expected=%h", DO, 32'd0);
    end
    OE = 1'b1; #1;
    checks++;
    if (DO !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL oe_high_hold DO=%h expected=%h", DO, 32'hAABBCCDD);
    end
  endtask

  // ctrl_v 7: auto-reload to 0 after the match; ctrl_v 5: count continues to 6.
  task automatic test_count_match(input logic [31:0] ctrl_v, input string nm);
    logic [31:0] exp_c;
    do_reset();
    wr32(14'd1, 32'd3);
    wr32(14'd2, 32'd5);
    wr32(14'd0, ctrl_v);
    for (int n = 1; n <= 28; n++) begin
      rd32(14'd3);
      exp_c = 32'((n - 1) / 4);
      if (n > 24 && ctrl_v[1]) exp_c = 32'd0;
      checks++;
      if (DO !== exp_c) begin
        failures++;
        $display("FAIL %s_count n=%0d DO=%h expected=%h", nm, n, DO, exp_c);
      end
      checks++;
      if (irq !== (n >= 24)) begin
        failures++;
        $display("FAIL %s_irq n=%0d irq=%b expected=%b", nm, n, irq, (n >= 24));
      end
    end
  endtask

  task automatic test_wrap();
    wr32(14'd0, 32'd0);
    wr32(14'd4, 32'd1);
    wr32(14'd3, 32'hFFFFFFFF);
    wr32(14'd1, 32'd0);
    wr32(14'd0, 32'd5);
    rd32(14'd3);
    checks++;
    if (DO !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_pre DO=%h expected=%h", DO, 32'hFFFFFFFF);
    end
    rd32(14'd3);
    checks++;
    if (DO !== 32'd0) begin
      failures++;
      $display("FAIL wrap_zero DO=%h expected=%h", DO, 32'd0);
    end
    rd32(14'd4);
    checks++;
    if (DO !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL wrap_nomatch status=%h irq=%b expected status=0 irq=0", DO, irq);
    end
  endtask

  task automatic test_w1c_race();
    do_reset();
    wr32(14'd2, 32'd3);
    wr32(14'd0, 32'd5);
    idle(); idle(); idle();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL race_pre irq=%b expected=0", irq);
    end
    wr32(14'd4, 32'd1);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL race_set_wins irq=%b expected=1", irq);
    end
    wr32(14'd4, 32'd1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL race_clear irq=%b expected=0", irq);
    end
    rd32(14'd4);
    checks++;
    if (DO !== 32'd0) begin
      failures++;
      $display("FAIL race_status DO=%h expected=%h", DO, 32'd0);
    end
  endtask

  task automatic test_rst_midop();
    do_reset();
    wr32(14'd2, 32'd2);
    wr32(14'd0, 32'd7);
    idle(); idle(); idle(); idle();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_irq irq=%b expected=1", irq);
    end
    rd32(14'd3);
    rst = 1'b1;
    rd32(14'd3);
    rst = 1'b0;
    checks++;
    if (DO !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush DO=%h irq=%b expected DO=0 irq=0", DO, irq);
    end
    rd32(14'd0);
    checks++;
    if (DO !== 32'd0) begin
      failures++;
      $display("FAIL rst_ctrl DO=%h expected=%h", DO, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      rd32(14'd3);
      checks++;
      if (DO !== 32'd0) begin
        failures++;
        $display("FAIL rst_count_idle k=%0d DO=%h expected=%h", k, DO, 32'd0);
      end
    end
    wr32(14'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      rd32(14'd3);
      checks++;
      if (DO !== 32'(k)) begin
        failures++;
        $display("FAIL rst_reenable k=%0d DO=%h expected=%h", k, DO, 32'(k));
      end
    end
  endtask

  task automatic test_random();
    logic        cs_v;
    logic [3:0]  web_v;
    logic [13:0] a_v;
    logic [31:0] di_v;
    logic [31:0] exp_do;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      OE    = ($urandom % 4) != 0;
      cs_v  = ($urandom % 4) != 0;
      a_v   = 14'($urandom);
      web_v = ($urandom % 2) ? 4'hF : 4'($urandom);
      di_v  = $urandom;
      if (a_v[2:0] inside {3'd1, 3'd2, 3'd3} && ($urandom % 4) != 0)
        di_v = $urandom_range(0, 6);
      cyc(cs_v, web_v, a_v, di_v);
      exp_do = OE ? m_do : 32'd0;
      checks++;
      if (DO !== exp_do) begin
        failures++;
        $display("FAIL rand_do n=%0d DO=%h expected=%h", n, DO, exp_do);
      end
      checks++;
      if (irq !== (m_match & m_ctrl[2])) begin
        failures++;
        $display("FAIL rand_irq n=%0d irq=%b expected=%b", n, irq, m_match & m_ctrl[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_count_match(32'd7, "reload");
    test_count_match(32'd5, "noreload");
    test_wrap();
    test_w1c_race();
    test_rst_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_mmio_timer.md
Name: dm_mmio_timer

Overview:
- Memory-mapped timer/compare peripheral that acts as a responder on the data-memory port protocol the CPU already drives.
- The protocol is the SRAM-style port:
  - chip select, output enable
  - active-low per-byte write enables
  - 14-bit word address, 32-bit data in/out
  - synchronous read with one-cycle latency
- Sits beside the data SRAM. A top-level address decoder drives CS so CPU loads/stores reach it without CPU changes.
- Provides a prescaled 32-bit counter, compare match, auto-reload and a level interrupt.

Parameters:
ADDR_W, 14, word-address width of A (matches data-memory port)
SEL_W, 3, low address bits used for register select; upper bits ignored (aliasing)
PRE_W, 16, width of prescaler register and prescale counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
CS  input  1  select; 0 = no access this cycle
OE  input  1  output enable; DO forced to 0 when low
WEB  input  4  active-low byte write enables, bit i -> DI[8i+7:8i]; 4'b1111 = read
A  input  ADDR_W  word address; only A[SEL_W-1:0] decoded
DI  input  32  write data
DO  output  32  read data, valid the cycle after the read access
irq  output  1  level interrupt = STATUS.match & CTRL.irq_en

Behaviour:
Register map (A[2:0]):
- 0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 1 PRESCALE: bits [PRE_W-1:0].
- 2 COMPARE: 32 bits.
- 3 COUNT: 32 bits.
- 4 STATUS: bit0 match, write-1-to-clear.
- 5..7: read 0, writes ignored.

Reset (rst=1 at edge):
- All registers, the prescale counter and the DO latch clear to 0; irq=0.

Access rules:
- Write: CS=1 and any WEB bit 0. Only lanes with WEB[i]=0 update. The DO latch holds its previous value.
- Read: CS=1 and WEB=4'b1111. The selected register value is captured into the DO latch at the edge and presented on DO the next cycle. The captured value is the pre-edge value, so same-edge counter updates are not visible.
- CS=0: no state change from the bus; the DO latch holds.
- DO = OE ? latch : 0, combinational on OE.

Prescaler/count:
- enable=0:
  - pre_cnt forced to 0.
  - COUNT holds.
- enable=1:
  - pre_cnt increments each cycle.
  - When pre_cnt == PRESCALE there is a tick: pre_cnt <= 0. So a tick occurs every PRESCALE+1 cycles, and PRESCALE=0 gives a tick every cycle.
- On a tick:
  - If COUNT == COMPARE: set STATUS.match. COUNT <= auto_reload ? 0 : COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - Arithmetic is 32-bit modulo: 0xFFFFFFFF wraps to 0 with no flag.

Simultaneous events:
- Bus write to COUNT in a tick cycle: the written bytes win. Unwritten bytes take the tick-updated value.
- Write to PRESCALE (any lane): pre_cnt <= 0 in the same edge.
- STATUS W1C in the same cycle as a match set: set wins, match stays 1.
- Write to CTRL clearing enable in a tick cycle: that tick still takes effect. pre_cnt is 0 from the next cycle.
- Writing COMPARE does not itself set match; the comparison occurs only on a tick.
- rst mid-operation: everything returns to reset values the same edge; any pending read data is lost (DO=0 next cycle).

Decomposition:
- Shared package dm_mmio_pkg:
  - register-select localparams (REG_CTRL=0 .. REG_STATUS=4)
  - CTRL bit-position constants
  - a typedef for the CTRL fields
  - a byte-lane write-merge function (old, new, web) -> merged
- One natural sub-module, dm_mmio_prescaler: holds pre_cnt and produces the tick pulse (inputs enable, prescale, clear).

Test Plan:
1. Reset, then read each of addresses 0..7 with OE=1 -> DO=0 one cycle after each read. Check DO=0 whenever OE=0.
2. Write COUNT=0x11223344 with WEB=4'b1101 (only lane 1) -> readback COUNT=0x00003300. Then write WEB=4'b0000 with DI=0xAABBCCDD -> readback 0xAABBCCDD.
3. PRESCALE=3, COMPARE=5, CTRL=0x7 -> COUNT steps every 4 cycles. STATUS.match=1 and irq=1 on the tick where COUNT==5. The next COUNT is 0 (auto_reload).
4. Same as 3 with CTRL=0x5 (no auto_reload) -> match is set and COUNT continues to 6. Preload COUNT=0xFFFFFFFF -> the next tick gives 0 and match is not set (COMPARE≠).
5. Issue STATUS W1C (DI=1) in exactly the match tick cycle -> match remains 1. A W1C one cycle later -> match=0, irq=0.
6. Assert rst while enabled with a read in flight -> next cycle DO=0, COUNT=0, CTRL=0, irq=0. Subsequent ticks do not occur until enable is written.
